// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and helpers for the UART transmit arbiter
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_START,
      ARB_WAIT
   } arb_state_t;

   // Round-robin successor that also works for non-power-of-2 requester counts
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter handshake bundle for the UART transmit arbiter
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4
) ();
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_start;
   logic [7:0]        tx_din;
   logic              tx_done_tick;
   logic [IDW-1:0]    grant_id;
   logic              busy;

   modport master (
      output req_valid, req_data, req_last, tx_done_tick,
      input  req_ready, tx_start, tx_din, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_done_tick,
      output req_ready, tx_start, tx_din, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin search starting at a pointer
module rr_picker #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_ptr,
   output logic                    o_found,
   output logic [$clog2(NREQ)-1:0] o_idx
);
   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0] w_cand;

   // Walk from the farthest candidate back to i_ptr so the nearest valid one wins
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_cand = IDW'((int'(i_ptr) + k) % NREQ);
         if (i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte-stream requesters
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   uart_tx_arbiter_if.slave io_bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int BCW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

   arb_state_t     r_state;
   arb_state_t     w_state_nxt;
   logic [IDW-1:0] r_grant_id;
   logic [IDW-1:0] r_rr_ptr;
   logic [7:0]     r_tx_din;
   logic           r_last_q;
   logic           r_lock;
   logic [BCW-1:0] r_burst_cnt;

   logic [NREQ-1:0] w_eligible;
   logic [NREQ-1:0] w_ready;
   logic [IDW-1:0]  w_ptr;
   logic [IDW-1:0]  w_idx;
   logic            w_found;
   logic            w_tx_start;
   logic [7:0]      w_sel_data;
   logic            w_sel_last;
   logic [BCW-1:0]  w_cnt_inc;
   logic            w_release;

   // While locked, only the owner can win; reusing the picker keeps one search path
   assign w_eligible = r_lock ? (io_bus.req_valid & (NREQ'(1) << r_grant_id)) : io_bus.req_valid;
   assign w_ptr      = r_lock ? r_grant_id : r_rr_ptr;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .i_req   (w_eligible),
      .i_ptr   (w_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   always_comb begin
      w_sel_data = 8'h00;
      w_sel_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_idx == IDW'(i)) begin
            w_sel_data = io_bus.req_data[8*i +: 8];
            w_sel_last = io_bus.req_last[i];
         end
      end
   end

   assign w_cnt_inc = r_burst_cnt + BCW'(1);
   assign w_release = r_last_q || ((MAX_BURST != 0) && (w_cnt_inc == BCW'(MAX_BURST)));

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = '0;
      w_tx_start  = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_found) begin
               w_ready[w_idx] = 1'b1;
               w_state_nxt    = ARB_START;
            end
         end
         ARB_START: begin
            w_tx_start  = 1'b1;
            w_state_nxt = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (io_bus.tx_done_tick) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ARB_IDLE;
         r_grant_id  <= '0;
         r_rr_ptr    <= '0;
         r_tx_din    <= 8'h00;
         r_last_q    <= 1'b0;
         r_lock      <= 1'b0;
         r_burst_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ARB_IDLE && w_found) begin
            r_tx_din   <= w_sel_data;
            r_grant_id <= w_idx;
            r_last_q   <= w_sel_last;
         end
         if (r_state == ARB_WAIT && io_bus.tx_done_tick) begin
            if (w_release) begin
               r_lock      <= 1'b0;
               r_burst_cnt <= '0;
               r_rr_ptr    <= IDW'(rr_next(int'(r_grant_id), NREQ));
            end else begin
               r_lock      <= 1'b1;
               r_burst_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign io_bus.req_ready = w_ready;
   assign io_bus.tx_start  = w_tx_start;
   assign io_bus.tx_din    = r_tx_din;
   assign io_bus.grant_id  = r_grant_id;
   assign io_bus.busy      = (r_state != ARB_IDLE) || r_lock;
endmodule
